norm_lshift: RTL and testbench
==============================

# norm_lshift

Sequential left-normalizer for the approximate divider datapath. Accepts a 2n-bit operand and shifts it left one bit per clock until its MSB is 1. Reports the normalized value and the number of positions shifted. The downstream right-shift (denormalization) stage consumes `shift_amt` to restore the result's scale, so this block is the inverse end of that shift.

## Interface

Parameters:
- `n`, default 8. Half data width; data path is 2n bits. Constraint: n ≥ 2, so that 2n-1 fits in n bits.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: request. Sampled only when `busy`=0.
- `in_norm`, input, 2n: operand. Captured on the accepting edge.
- `norm_out`, output, 2n: normalized operand. Registered.
- `shift_amt`, output, n: left-shift count, 0..2n-1. Registered.
- `zero`, output, 1: operand was all-zero. Registered.
- `busy`, output, 1: high while in SHIFT state.
- `done`, output, 1: one-cycle completion pulse.

## Operation

- State machine has two states: IDLE and SHIFT. Internal registers are `work` (2n bits) and `cnt` (n bits).
- **IDLE:**
  - `start`=1 at an edge: `work`←`in_norm`, `cnt`←0, go to SHIFT.
  - `start`=0: stay in IDLE.
- **SHIFT, evaluated each edge:**
  - `work`==0: `norm_out`←0, `shift_amt`←0, `zero`←1, `done`←1, go to IDLE.
  - `work`[2n-1]==1: `norm_out`←`work`, `shift_amt`←`cnt`, `zero`←0, `done`←1, go to IDLE.
  - Otherwise: `work`←`work`<<1 with a 0 filled into the LSB, `cnt`←`cnt`+1, stay in SHIFT.
- `done` is cleared on every edge where it is not set.
- `start` while `busy`=1 is ignored. No queuing.
- `norm_out`, `shift_amt` and `zero` hold their last values until the next completion. They are not cleared at request accept.
- The count cannot wrap. A nonzero operand terminates at `cnt` ≤ 2n-1.
- Invariant for nonzero operands: `norm_out` == `in_norm` << `shift_amt` (truncated to 2n bits), with `norm_out`[2n-1]==1.

## Timing

- Reset values: state=IDLE; `work`, `cnt`, `norm_out`, `shift_amt` are all 0; `zero`, `busy`, `done` are all 0.
- Reset asserted mid-operation aborts immediately. `done` does not pulse for the aborted request.
- Latency: let the accepting edge be E0 and z = leading-zero count of a nonzero operand.
  - `done` and the result are visible after edge E(z+1).
  - An all-zero operand completes after E1.
- `busy` is high in the cycles after E0 through E(z+1); it falls at the same edge where `done` rises.
- Back-to-back requests: `start` held high in the `done` cycle is accepted at the next edge. Minimum issue interval is z+2 cycles.
- `in_norm` is don't-care except at the accepting edge.

## Test plan

Use n=8 for all scenarios.
- **Already normalized:** `in_norm`=0x8000 with `start` pulse → `done` after E1, `norm_out`=0x8000, `shift_amt`=0, `zero`=0.
- **Worst case:** `in_norm`=0x0001 → `done` after E16, `norm_out`=0x8000, `shift_amt`=15, `busy` high for 16 cycles.
- **Mid value:** `in_norm`=0x0123 → `done` after E8, `norm_out`=0x9180, `shift_amt`=7.
- **Zero operand:** `in_norm`=0x0000 → `done` after E1, `zero`=1, `norm_out`=0, `shift_amt`=0.
- **Start while busy:**
  - Sequence: 0x0001 accepted; at E3 drive `start`=1 with 0x4000.
  - Required: request ignored; single `done` with `shift_amt`=15; then 0x4000 issued after `done` gives `shift_amt`=1.
- **Reset mid-op:**
  - Sequence: 0x0010 accepted; `rst_n` low at cycle 3.
  - Required: all outputs 0 asynchronously; no `done`; after release, 0x0010 gives `shift_amt`=11, `norm_out`=0x8000.

Source files
------------

// File: rtl/norm_lshift.sv
// norm_lshift: sequential left-normalizer for the approximate divider datapath.
// A captured 2n-bit operand is shifted left one bit per clock until its MSB
// is set. The shift count is reported so the downstream denormalizer can
// restore the original scale with a matching right shift.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   start     - request, sampled only while busy is low
//   in_norm   - 2n-bit operand, captured on the accepting edge
//   norm_out  - normalized operand (registered, held until next completion)
//   shift_amt - number of positions shifted, 0..2n-1 (registered)
//   zero      - operand was all-zero (registered)
//   busy      - high while the shifter is working
//   done      - one-cycle completion pulse
module norm_lshift #(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*n-1:0] in_norm,
  output logic [2*n-1:0] norm_out,
  output logic [n-1:0]   shift_amt,
  output logic           zero,
  output logic           busy,
  output logic           done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2*n-1:0]   work_q, work_d;
  logic [n-1:0]     cnt_q, cnt_d;
  logic [2*n-1:0]   norm_d;
  logic [n-1:0]     amt_d;
  logic             zero_d;
  logic             done_d;

  // Next-state and next-datapath evaluation
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    norm_d  = norm_out;
    amt_d   = shift_amt;
    zero_d  = zero;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = in_norm;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (work_q == '0) begin
          // An all-zero operand never normalizes; report it instead of
          // shifting forever.
          norm_d  = '0;
          amt_d   = '0;
          zero_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (work_q[2*n-1]) begin
          norm_d  = work_q;
          amt_d   = cnt_q;
          zero_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          // A nonzero operand reaches the MSB within 2n-1 shifts, so cnt
          // cannot wrap.
          work_d = {work_q[2*n-2:0], 1'b0};
          cnt_d  = cnt_q + n'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      norm_out  <= '0;
      shift_amt <= '0;
      zero      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      norm_out  <= norm_d;
      shift_amt <= amt_d;
      zero      <= zero_d;
      done      <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_norm_lshift.sv
module tb_norm_lshift;

  localparam int N = 8;
  localparam int W = 2 * N;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] in_norm;
  logic [W-1:0] norm_out;
  logic [N-1:0] shift_amt;
  logic         zero;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] norm;
    logic [N-1:0] amt;
    logic         zero;
  } exp_t;

  exp_t sb_q[$];

  norm_lshift #(.n(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_norm   (in_norm),
    .norm_out  (norm_out),
    .shift_amt (shift_amt),
    .zero      (zero),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: leading-zero count by scanning from the MSB.
  function automatic int lzc(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) return W - 1 - i;
    end
    return W;
  endfunction

  function automatic exp_t model(input logic [W-1:0] v);
    exp_t e;
    if (v == '0) begin
      e.norm = '0;
      e.amt  = '0;
      e.zero = 1'b1;
    end else begin
      e.norm = v << lzc(v);
      e.amt  = N'(lzc(v));
      e.zero = 1'b0;
    end
    return e;
  endfunction

  function automatic int exp_latency(input logic [W-1:0] v);
    return (v == '0) ? 1 : lzc(v) + 1;
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: got norm_out=%h shift_amt=%0d, required no done", norm_out, shift_amt);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (norm_out !== e.norm || shift_amt !== e.amt || zero !== e.zero) begin
          errors++;
          $display("FAIL sb_result: got norm_out=%h shift_amt=%0d zero=%b, required norm_out=%h shift_amt=%0d zero=%b",
                   norm_out, shift_amt, zero, e.norm, e.amt, e.zero);
        end
      end
    end
  end

  // Drive a request from an idle cycle; returns #1 after the accepting edge.
  task automatic send(input logic [W-1:0] v);
    start   = 1'b1;
    in_norm = v;
    sb_q.push_back(model(v));
    @(posedge clk);
    #1;
    start   = 1'b0;
    in_norm = $urandom;
  endtask

  // Count edges until done is seen; -1 if the budget runs out.
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cycles = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start   = 1'b1;
    in_norm = 16'h0123;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({norm_out, shift_amt, zero, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got norm_out=%h shift_amt=%0d zero=%b busy=%b done=%b, required all 0",
               norm_out, shift_amt, zero, busy, done);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_normalized();
    int c;
    send(16'h8000);
    wait_done(c);
    checks++;
    if (c !== 1 || norm_out !== 16'h8000 || shift_amt !== 8'd0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL normalized: got lat=%0d norm_out=%h shift_amt=%0d zero=%b, required lat=1 8000 0 0",
               c, norm_out, shift_amt, zero);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || norm_out !== 16'h8000) begin
      errors++;
      $display("FAIL done_pulse_hold: got done=%b norm_out=%h, required done=0 norm_out=8000", done, norm_out);
    end
  endtask

  task automatic test_worst();
    int busy_cycles = 0;
    int edges = 0;
    send(16'h0001);
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cycles++;
      if (done) break;
      @(posedge clk);
      #1;
      edges++;
    end
    checks++;
    if (edges !== 16 || busy_cycles !== 16 || busy !== 1'b0) begin
      errors++;
      $display("FAIL worst_timing: got edges=%0d busy_cycles=%0d busy=%b, required 16 16 0", edges, busy_cycles, busy);
    end
    checks++;
    if (norm_out !== 16'h8000 || shift_amt !== 8'd15) begin
      errors++;
      $display("FAIL worst_result: got norm_out=%h shift_amt=%0d, required 8000 15", norm_out, shift_amt);
    end
  endtask

  task automatic test_mid();
    int c;
    send(16'h0123);
    wait_done(c);
    checks++;
    if (c !== 8 || norm_out !== 16'h9180 || shift_amt !== 8'd7) begin
      errors++;
      $display("FAIL mid_value: got lat=%0d norm_out=%h shift_amt=%0d, required lat=8 9180 7", c, norm_out, shift_amt);
    end
  endtask

  task automatic test_zero();
    int c;
    send(16'h0000);
    wait_done(c);
    checks++;
    if (c !== 1 || zero !== 1'b1 || norm_out !== 16'h0000 || shift_amt !== 8'd0) begin
      errors++;
      $display("FAIL zero_operand: got lat=%0d zero=%b norm_out=%h shift_amt=%0d, required lat=1 1 0000 0",
               c, zero, norm_out, shift_amt);
    end
  endtask

  task automatic test_start_while_busy();
    int c;
    send(16'h0001);
    repeat (2) @(posedge clk);
    #1;
    start   = 1'b1;
    in_norm = 16'h4000;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(c);
    checks++;
    if (c !== 13 || shift_amt !== 8'd15 || norm_out !== 16'h8000) begin
      errors++;
      $display("FAIL busy_ignore: got edges=%0d shift_amt=%0d norm_out=%h, required 13 15 8000", c, shift_amt, norm_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_no_queue: got busy=%b, required 0", busy);
    end
    send(16'h4000);
    wait_done(c);
    checks++;
    if (c !== 2 || shift_amt !== 8'd1 || norm_out !== 16'h8000) begin
      errors++;
      $display("FAIL after_busy: got lat=%0d shift_amt=%0d norm_out=%h, required 2 1 8000", c, shift_amt, norm_out);
    end
  endtask

  task automatic test_reset_mid_op();
    int c;
    send(16'h0010);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    checks++;
    if ({norm_out, shift_amt, zero, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_abort: got norm_out=%h shift_amt=%0d zero=%b busy=%b done=%b, required all 0",
               norm_out, shift_amt, zero, busy, done);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: got done=%b busy=%b, required 0 0", done, busy);
    end
    send(16'h0010);
    wait_done(c);
    checks++;
    if (c !== 12 || shift_amt !== 8'd11 || norm_out !== 16'h8000) begin
      errors++;
      $display("FAIL reset_recover: got lat=%0d shift_amt=%0d norm_out=%h, required 12 11 8000", c, shift_amt, norm_out);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    send(16'h0800);
    wait_done(c);
    checks++;
    if (c !== 5) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d, required 5", c);
    end
    // Held in the done cycle: must be accepted at the very next edge.
    send(16'h00FF);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b, required 1", busy);
    end
    wait_done(c);
    checks++;
    if (c !== 9 || norm_out !== 16'hFF00 || shift_amt !== 8'd8) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d norm_out=%h shift_amt=%0d, required 9 ff00 8", c, norm_out, shift_amt);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    int c;
    for (int k = 0; k < 24; k++) begin
      v = W'($urandom);
      v = v >> $urandom_range(0, W);
      send(v);
      wait_done(c);
      checks++;
      if (c !== exp_latency(v)) begin
        errors++;
        $display("FAIL rand_latency: in=%h got lat=%0d, required %0d", v, c, exp_latency(v));
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    in_norm = '0;
    #1;
    test_reset();
    test_normalized();
    test_worst();
    test_mid();
    test_zero();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() !== 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending results, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
